// File: rtl/func_decoder.sv
// Registered 3-to-8 decoder with three OR-of-minterm function outputs.
// Define FUNC_DECODER_PROG_EN to make the minterm masks run-time writable.
module func_decoder #(
  parameter logic [7:0] F1_MINTERMS = 8'h96,
  parameter logic [7:0] F2_MINTERMS = 8'hE8,
  parameter logic [7:0] F3_MINTERMS = 8'h55
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] i,
`ifdef FUNC_DECODER_PROG_EN
  input  logic       prog_we,
  input  logic [1:0] prog_sel,
  input  logic [7:0] prog_data,
`endif
  output logic [7:0] dec,
  output logic [3:1] F,
  output logic       valid
);

  logic [7:0] dec_next;
  logic [3:1] f_next;
  logic [7:0] mask [1:3];

  assign dec_next = 8'h01 << i;

`ifdef FUNC_DECODER_PROG_EN
  logic [7:0] mask_reg [1:3];

  // Samples taken on the same edge as a write still see the old mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_reg[1] <= F1_MINTERMS;
      mask_reg[2] <= F2_MINTERMS;
      mask_reg[3] <= F3_MINTERMS;
    end else if (prog_we) begin
      case (prog_sel)
        2'd1:    mask_reg[1] <= prog_data;
        2'd2:    mask_reg[2] <= prog_data;
        2'd3:    mask_reg[3] <= prog_data;
        default: ;
      endcase
    end
  end

  assign mask[1] = mask_reg[1];
  assign mask[2] = mask_reg[2];
  assign mask[3] = mask_reg[3];
`else
  assign mask[1] = F1_MINTERMS;
  assign mask[2] = F2_MINTERMS;
  assign mask[3] = F3_MINTERMS;
`endif

  generate
    for (genvar gi = 1; gi <= 3; gi++) begin : g_func
      assign f_next[gi] = |(dec_next & mask[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec   <= 8'h00;
      F     <= 3'b000;
      valid <= 1'b0;
    end else if (en) begin
      dec   <= dec_next;
      F     <= f_next;
      valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_func_decoder.sv
// Directed, table-driven bench for func_decoder (default masks: sum, carry, even).
module tb_func_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] i;
  logic [7:0] dec;
  logic [3:1] F;
  logic       valid;
`ifdef FUNC_DECODER_PROG_EN
  logic       prog_we;
  logic [1:0] prog_sel;
  logic [7:0] prog_data;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  func_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .i        (i),
`ifdef FUNC_DECODER_PROG_EN
    .prog_we  (prog_we),
    .prog_sel (prog_sel),
    .prog_data(prog_data),
`endif
    .dec      (dec),
    .F        (F),
    .valid    (valid)
  );

  typedef struct {
    logic [2:0] i;
    logic [7:0] dec;
    logic [3:1] f;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] e_dec,
                           input logic [3:1] e_f, input logic e_valid);
    check({name, ".dec"}, dec, e_dec);
    check({name, ".F"}, {5'b0, F}, {5'b0, e_f});
    check({name, ".valid"}, {7'b0, valid}, {7'b0, e_valid});
  endtask

  // Apply on the falling edge, observe 1 ns after the next rising edge.
  task automatic step(input logic e, input logic [2:0] sel);
    @(negedge clk);
    en = e;
    i  = sel;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // F as {F3,F2,F1}: F1 = odd parity, F2 = majority, F3 = i[0]==0
    vecs[0]  = '{3'd0, 8'h01, 3'b100};
    vecs[1]  = '{3'd1, 8'h02, 3'b001};
    vecs[2]  = '{3'd2, 8'h04, 3'b101};
    vecs[3]  = '{3'd3, 8'h08, 3'b010};
    vecs[4]  = '{3'd4, 8'h10, 3'b101};
    vecs[5]  = '{3'd5, 8'h20, 3'b010};
    vecs[6]  = '{3'd6, 8'h40, 3'b110};
    vecs[7]  = '{3'd7, 8'h80, 3'b011};
    vecs[8]  = '{3'd5, 8'h20, 3'b010};
    vecs[9]  = '{3'd2, 8'h04, 3'b101};
    vecs[10] = '{3'd7, 8'h80, 3'b011};
    vecs[11] = '{3'd0, 8'h01, 3'b100};
    vecs[12] = '{3'd6, 8'h40, 3'b110};
    vecs[13] = '{3'd1, 8'h02, 3'b001};
    vecs[14] = '{3'd4, 8'h10, 3'b101};
    vecs[15] = '{3'd7, 8'h80, 3'b011};

    rst_n = 1'b0;
    en    = 1'b1;
    i     = 3'd5;
`ifdef FUNC_DECODER_PROG_EN
    prog_we   = 1'b0;
    prog_sel  = 2'd0;
    prog_data = 8'h00;
`endif

    // Reset held while en=1 and i toggles
    for (int k = 0; k < 3; k++) begin
      step(1'b1, (k % 2 == 0) ? 3'd5 : 3'd2);
      check_out("reset_hold", 8'h00, 3'b000, 1'b0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd0);
    check_out("first_after_reset", 8'h01, 3'b100, 1'b1);

    // Sweep and latency: i changes every edge
    for (int k = 0; k < 16; k++) begin
      step(1'b1, vecs[k].i);
      check_out($sformatf("vec%0d_i%0d", k, vecs[k].i), vecs[k].dec, vecs[k].f, 1'b1);
    end

    // Hold with en=0 after i=7 registered
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 3'd0);
      check_out($sformatf("hold%0d", k), 8'h80, 3'b011, 1'b1);
    end

    // Asynchronous reset between edges
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 3'b000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 3'd3);
    check_out("after_async_reset", 8'h08, 3'b010, 1'b1);

`ifdef FUNC_DECODER_PROG_EN
    // Write F3 mask together with a sample: old mask applies this edge
    @(negedge clk);
    en = 1'b1; i = 3'd7;
    prog_we = 1'b1; prog_sel = 2'd3; prog_data = 8'h80;
    @(posedge clk);
    #1;
    check_out("prog_same_edge", 8'h80, 3'b011, 1'b1);
    @(negedge clk);
    prog_we = 1'b0;
    step(1'b1, 3'd7);
    check_out("prog_new_mask", 8'h80, 3'b111, 1'b1);

    // sel=0 write is ignored and does not disturb registered F
    @(negedge clk);
    en = 1'b0;
    prog_we = 1'b1; prog_sel = 2'd0; prog_data = 8'h00;
    @(posedge clk);
    #1;
    check_out("prog_sel0_hold", 8'h80, 3'b111, 1'b1);
    @(negedge clk);
    prog_we = 1'b0;
    step(1'b1, 3'd7);
    check_out("prog_sel0_ignored", 8'h80, 3'b111, 1'b1);
    step(1'b1, 3'd6);
    check_out("prog_i6", 8'h40, 3'b010, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
